// File: rtl/fetch_sequencer_if.sv
// Bundles the PC-control, instruction-ROM and decode handshake signals
// around the fetch sequencer. The sequencer uses the master view; the
// PC, ROM, decode and execute side use the slave view.
interface fetch_sequencer_if #(
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 32
);
  // PC control
  logic               pcRst;
  logic               pcLd;
  logic               pcSrc;
  logic               jmp;
  logic [ADDR_W-1:0]  pcOffset;
  logic [ADDR_W-1:0]  pcAddr;
  // Instruction ROM
  logic [ADDR_W-1:0]  imemAddr;
  logic [INSTR_W-1:0] imemData;
  // Decode handshake
  logic [INSTR_W-1:0] instrOut;
  logic               instrValid;
  logic               instrReady;
  // Branch outcome from execute
  logic               brResolved;
  logic               brTaken;

  modport master (
    input  pcAddr, imemData, instrReady, brResolved, brTaken,
    output pcRst, pcLd, pcSrc, jmp, pcOffset, imemAddr, instrOut, instrValid
  );

  modport slave (
    output pcAddr, imemData, instrReady, brResolved, brTaken,
    input  pcRst, pcLd, pcSrc, jmp, pcOffset, imemAddr, instrOut, instrValid
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: walks one instruction at a time through
// FETCH -> CAPTURE -> OUT -> UPD, holding in BRWAIT when a conditional
// branch needs its outcome from execute. Every control output is
// registered; only imemAddr passes straight through from the PC.
module fetch_sequencer #(
  parameter int          ADDR_W  = 5,
  parameter int          INSTR_W = 32,
  parameter logic [5:0]  OPC_BR  = 6'b000100,
  parameter logic [5:0]  OPC_J   = 6'b000010
) (
  input  logic              clk,
  input  logic              rstN,
  fetch_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    RST,
    FETCH,
    CAPTURE,
    OUT,
    BRWAIT,
    UPD
  } state_t;

  state_t             state, state_nx;
  logic               pc_rst,    pc_rst_nx;
  logic               pc_ld,     pc_ld_nx;
  logic               pc_src,    pc_src_nx;
  logic               jmp,       jmp_nx;
  logic [ADDR_W-1:0]  pc_offset, pc_offset_nx;
  logic [INSTR_W-1:0] instr,     instr_nx;
  logic               valid,     valid_nx;

  logic [5:0]         opcode;

  assign opcode = instr[INSTR_W-1 -: 6];

  // ROM address follows the PC combinationally so the ROM samples it in FETCH.
  assign bus.imemAddr   = bus.pcAddr;
  assign bus.pcRst      = pc_rst;
  assign bus.pcLd       = pc_ld;
  assign bus.pcSrc      = pc_src;
  assign bus.jmp        = jmp;
  assign bus.pcOffset   = pc_offset;
  assign bus.instrOut   = instr;
  assign bus.instrValid = valid;

  // State and registered outputs; reset aborts any pending branch or jump.
  // NOTE: clocked state uses non-blocking (<=) so every register samples
  // the pre-edge values; the combinational block below uses blocking (=).
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state     <= RST;
      pc_rst    <= 1'b1;
      pc_ld     <= 1'b0;
      pc_src    <= 1'b0;
      jmp       <= 1'b0;
      pc_offset <= '0;
      instr     <= '0;
      valid     <= 1'b0;
    end else begin
      state     <= state_nx;
      pc_rst    <= pc_rst_nx;
      pc_ld     <= pc_ld_nx;
      pc_src    <= pc_src_nx;
      jmp       <= jmp_nx;
      pc_offset <= pc_offset_nx;
      instr     <= instr_nx;
      valid     <= valid_nx;
    end
  end

  // Next-state and next-output decode for the fetch walk.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_nx     = state;
    pc_rst_nx    = 1'b0;
    pc_ld_nx     = 1'b0;
    pc_src_nx    = 1'b0;
    jmp_nx       = 1'b0;
    pc_offset_nx = pc_offset;
    instr_nx     = instr;
    valid_nx     = valid;

    unique case (state)
      RST: begin
        state_nx = FETCH;
      end
      FETCH: begin
        state_nx = CAPTURE;
      end
      CAPTURE: begin
        instr_nx = bus.imemData;
        valid_nx = 1'b1;
        state_nx = OUT;
      end
      OUT: begin
        if (valid && bus.instrReady) begin
          valid_nx = 1'b0;
          if (opcode == OPC_J) begin
            pc_ld_nx     = 1'b1;
            jmp_nx       = 1'b1;
            pc_offset_nx = instr[ADDR_W-1:0];
            state_nx     = UPD;
          end else if (opcode == OPC_BR) begin
            pc_offset_nx = instr[ADDR_W-1:0];
            state_nx     = BRWAIT;
          end else begin
            pc_ld_nx = 1'b1;
            state_nx = UPD;
          end
        end
      end
      BRWAIT: begin
        if (bus.brResolved) begin
          pc_ld_nx  = 1'b1;
          pc_src_nx = bus.brTaken;
          state_nx  = UPD;
        end
      end
      UPD: begin
        state_nx = FETCH;
      end
      default: begin
        state_nx = RST;
      end
    endcase
  end

endmodule
